// File: rtl/dsp_alu_cmd_sequencer.sv
// Command sequencer that feeds dsp_4bits_seq_alu: serialises one packed command
// nibble by nibble onto the ALU bus, then captures and holds the ALU response.
module dsp_alu_cmd_sequencer #(
    parameter int CMD_NIBBLES    = 3,
    parameter int RESULT_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [4*CMD_NIBBLES-1:0] cmd_data,
    output logic                     alu_enabled,
    output logic [3:0]               alu_data,
    input  logic [3:0]               alu_result,
    input  logic [3:0]               alu_flags,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_result,
    output logic [3:0]               rsp_flags,
    output logic                     busy
);

    localparam int CMD_W  = 4 * CMD_NIBBLES;
    localparam int IDX_W  = (CMD_NIBBLES > 1) ? $clog2(CMD_NIBBLES) : 1;
    localparam int WAIT_W = (RESULT_LATENCY > 1) ? $clog2(RESULT_LATENCY) : 1;

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CMD_NIBBLES - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(RESULT_LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    generate
        if (CMD_NIBBLES < 1 || CMD_NIBBLES > 8 || RESULT_LATENCY < 1 || RESULT_LATENCY > 15) begin : g_bad_params
            $fatal(1, "dsp_alu_cmd_sequencer: CMD_NIBBLES must be 1..8 and RESULT_LATENCY 1..15");
        end
    endgenerate

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              alu_enabled_q, alu_enabled_d;
    logic [3:0]        alu_data_q, alu_data_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [3:0]        rsp_result_q, rsp_result_d;
    logic [3:0]        rsp_flags_q, rsp_flags_d;
    logic              busy_q, busy_d;

    // Outputs are computed one cycle ahead so every port comes straight from a flop.
    // The latched command is kept as a shift register: its low nibble is always the
    // next one to send, which avoids a variable part-select.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wait_d        = wait_q;
        cmd_d         = cmd_q;
        cmd_ready_d   = cmd_ready_q;
        alu_enabled_d = alu_enabled_q;
        alu_data_d    = alu_data_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d   = 1'b0;
                    idx_d         = '0;
                    alu_enabled_d = 1'b1;
                    alu_data_d    = cmd_data[3:0];
                    cmd_d         = cmd_data >> 4;
                    state_d       = ST_SEND;
                end
            end
            ST_SEND: begin
                if (idx_q == LAST_IDX) begin
                    alu_enabled_d = 1'b0;
                    alu_data_d    = 4'h0;
                    wait_d        = '0;
                    state_d       = ST_WAIT;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    alu_data_d = cmd_q[3:0];
                    cmd_d      = cmd_q >> 4;
                end
            end
            ST_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    rsp_result_d = alu_result;
                    rsp_flags_d  = alu_flags;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            wait_q        <= '0;
            cmd_q         <= '0;
            cmd_ready_q   <= 1'b0;
            alu_enabled_q <= 1'b0;
            alu_data_q    <= 4'h0;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= 4'h0;
            rsp_flags_q   <= 4'h0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wait_q        <= wait_d;
            cmd_q         <= cmd_d;
            cmd_ready_q   <= cmd_ready_d;
            alu_enabled_q <= alu_enabled_d;
            alu_data_q    <= alu_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            busy_q        <= busy_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign alu_enabled = alu_enabled_q;
    assign alu_data    = alu_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_dsp_alu_cmd_sequencer.sv
// Scoreboard bench for dsp_alu_cmd_sequencer: expected nibbles and responses are
// queued by the stimulus side and retired by an independent monitor.
module tb_dsp_alu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [11:0] cmd_data = 12'h000;
    logic        alu_enabled;
    logic [3:0]  alu_data;
    logic [3:0]  alu_result = 4'h0;
    logic [3:0]  alu_flags = 4'h0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  rsp_result;
    logic [3:0]  rsp_flags;
    logic        busy;

    dsp_alu_cmd_sequencer #(.CMD_NIBBLES(3), .RESULT_LATENCY(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .alu_enabled (alu_enabled),
        .alu_data    (alu_data),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flags   (rsp_flags),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         checks = 0;
    int         errors = 0;
    logic [3:0] nib_q[$];
    logic [7:0] rsp_q[$];
    int         accept_cnt = 0;
    int         last_accept = 0;
    bit         b2b_mode = 1'b0;
    bit         b2b_seen = 1'b0;
    logic       rsp_valid_prev = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flagFailure(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    // Monitor samples 1ns after the falling edge: inputs and outputs are both settled,
    // and a valid&ready pair seen here means the handshake happens on the next rising edge.
    always @(negedge clk) begin
        #1;
        if (reset) begin
            rsp_valid_prev = 1'b0;
        end else begin
            if (cmd_valid && cmd_ready) begin
                if (b2b_mode && b2b_seen)
                    checkOutput("accept_spacing", cyc - last_accept, 7);
                b2b_seen    = b2b_mode;
                last_accept = cyc;
                accept_cnt++;
            end
            if (alu_enabled) begin
                if (nib_q.size() == 0)
                    flagFailure("unexpected_alu_enabled");
                else
                    checkOutput("alu_data", {28'd0, alu_data}, {28'd0, nib_q.pop_front()});
            end else begin
                checkOutput("alu_data_idle", {28'd0, alu_data}, 32'd0);
            end
            if (rsp_valid && !rsp_valid_prev)
                checkOutput("rsp_latency", cyc - last_accept, 6);
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0)
                    flagFailure("unexpected_response");
                else
                    checkOutput("rsp_flags_result", {24'd0, rsp_flags, rsp_result}, {24'd0, rsp_q.pop_front()});
            end
            rsp_valid_prev = rsp_valid;
        end
    end

    task automatic pushExpected(input logic [11:0] cmd, input logic [3:0] res, input logic [3:0] flg);
        for (int k = 0; k < 3; k++) nib_q.push_back(cmd[4*k +: 4]);
        rsp_q.push_back({flg, res});
    endtask

    // Called on a falling edge; returns on the falling edge just after the accept edge.
    task automatic applyStimulus(input logic [11:0] cmd, input logic [3:0] res, input logic [3:0] flg);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            flagFailure("cmd_ready_timeout");
        end else begin
            cmd_valid  = 1'b1;
            cmd_data   = cmd;
            alu_result = res;
            alu_flags  = flg;
            pushExpected(cmd, res, flg);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic waitRsp(input string name);
        int n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) flagFailure(name);
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || !cmd_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (rsp_q.size() != 0 || !cmd_ready) flagFailure("drain_timeout");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;

        // Reset values, then release
        @(negedge clk);
        checkOutput("reset_outputs",
                    {17'd0, cmd_ready, alu_enabled, alu_data, rsp_valid, rsp_result, rsp_flags, busy},
                    32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("cmd_ready_after_reset", cmd_ready, 1);
        checkOutput("busy_after_reset", busy, 0);

        // Nibble order, enable window and single-cycle response with rsp_ready held
        rsp_ready = 1'b1;
        applyStimulus(12'h3A5, 4'h8, 4'h2);
        for (int c = 1; c <= 7; c++) begin
            checkOutput($sformatf("alu_enabled_c%0d", c), alu_enabled, (c <= 3) ? 1 : 0);
            checkOutput($sformatf("rsp_valid_c%0d", c), rsp_valid, (c == 6) ? 1 : 0);
            checkOutput($sformatf("busy_c%0d", c), busy, (c <= 6) ? 1 : 0);
            if (c == 6) begin
                checkOutput("rsp_result_c6", rsp_result, 4'h8);
                checkOutput("rsp_flags_c6", rsp_flags, 4'h2);
            end
            if (c == 7) checkOutput("cmd_ready_c7", cmd_ready, 1);
            @(negedge clk);
        end

        // Held response under backpressure, ALU inputs toggling, ignored command pulse
        rsp_ready = 1'b0;
        applyStimulus(12'h7C1, 4'h5, 4'h9);
        waitRsp("hold_rsp_timeout");
        base = accept_cnt;
        for (int c = 0; c < 5; c++) begin
            checkOutput("hold_rsp_valid", rsp_valid, 1);
            checkOutput("hold_rsp_result", rsp_result, 4'h5);
            checkOutput("hold_rsp_flags", rsp_flags, 4'h9);
            checkOutput("hold_cmd_ready", cmd_ready, 0);
            alu_result = 4'($urandom);
            alu_flags  = 4'($urandom);
            cmd_valid  = (c == 1);
            cmd_data   = 12'hFFF;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        checkOutput("hold_no_accept", accept_cnt, base);
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("post_hold_rsp_valid", rsp_valid, 0);
        checkOutput("post_hold_cmd_ready", cmd_ready, 1);
        checkOutput("post_hold_result_kept", rsp_result, 4'h5);
        checkOutput("post_hold_flags_kept", rsp_flags, 4'h9);

        // Reset during the second SEND cycle
        applyStimulus(12'h456, 4'h3, 4'h3);
        @(negedge clk);
        reset = 1'b1;
        nib_q.delete();
        rsp_q.delete();
        #2;
        checkOutput("abort_alu_enabled", alu_enabled, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rsp_result", rsp_result, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checkOutput("abort_no_rsp", rsp_valid, 0);
        end
        applyStimulus(12'h9E2, 4'h1, 4'hF);
        drain();

        // Back-to-back commands with cmd_valid and rsp_ready held high
        b2b_mode   = 1'b1;
        base       = accept_cnt;
        cmd_valid  = 1'b1;
        cmd_data   = 12'hB17;
        alu_result = 4'hC;
        alu_flags  = 4'h4;
        pushExpected(12'hB17, 4'hC, 4'h4);
        @(negedge clk);
        cmd_data = 12'h0F4;
        pushExpected(12'h0F4, 4'hE, 4'h6);
        waitRsp("b2b_rsp_timeout");
        alu_result = 4'hE;
        alu_flags  = 4'h6;
        for (int n = 0; n < 30 && accept_cnt < base + 2; n++) @(negedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        checkOutput("b2b_accepts", accept_cnt, base + 2);
        drain();
        b2b_mode = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("nibbles_all_sent", nib_q.size(), 0);
        checkOutput("final_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
